// File: rtl/matrix_packer_pkg.sv
// Shared types and constants for the matrix serialiser: read FSM states, default geometry,
// header layout and parameter sanity helpers.
package matrix_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_FETCH  = 2'd2,
    ST_STREAM = 2'd3
  } state_e;

  localparam int DIM_DEF       = 32;
  localparam int ELEM_W_DEF    = 8;
  localparam int SYM_W_DEF     = 2;
  localparam int SYMS_PER_ELEM = ELEM_W_DEF / SYM_W_DEF;

  // Header word is {transpose, bank, DIM-1}; the two control bits sit at the top.
  localparam int HDR_CTRL_W = 2;

  function automatic int syms_per_elem(input int elem_w, input int sym_w);
    return elem_w / sym_w;
  endfunction

  function automatic bit sym_w_divides(input int elem_w, input int sym_w);
    return (sym_w > 0) && ((elem_w % sym_w) == 0);
  endfunction

endpackage

// File: rtl/matrix_packer_bank.sv
// Simple dual-port element store for both ping-pong banks (bank select is the address MSB).
// One write and one synchronous read per cycle; rd_data holds until the next rd_en.
module matrix_packer_bank #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/matrix_packer.sv
// Double-buffered DIMxDIM matrix serialiser: commit -> first symbol 2 cycles later, SYM_W LSB-first.
// Output holds under out_ready=0; in_ready drops while the write bank is still queued (MATRIX_PACKER_HEADER_EN adds a header word).
module matrix_packer
  import matrix_packer_pkg::*;
#(
  parameter int DIM    = DIM_DEF,
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int SYM_W  = SYM_W_DEF,
  parameter int ADDR_W = $clog2(DIM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_row,
  input  logic [ADDR_W-1:0] in_col,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_commit,
  input  logic              transpose,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SYM_W-1:0]  out_data,
  output logic              out_first,
  output logic              out_last,
  output logic [1:0]        bank_full
);

  localparam int SPE       = syms_per_elem(ELEM_W, SYM_W);
  localparam int SYM_IDX_W = (SPE > 1) ? $clog2(SPE) : 1;
  localparam int CNT_W     = 2 * ADDR_W;
  localparam int RAM_AW    = CNT_W + 1;
  localparam logic [CNT_W-1:0]     ELEM_LAST = '1;
  localparam logic [SYM_IDX_W-1:0] SYM_LAST  = SYM_IDX_W'(SPE - 1);

  if (!sym_w_divides(ELEM_W, SYM_W)) begin : g_bad_sym_w
    $error("matrix_packer: SYM_W must divide ELEM_W");
  end
  if ((DIM < 2) || ((DIM & (DIM - 1)) != 0) || (ADDR_W != $clog2(DIM))) begin : g_bad_dim
    $error("matrix_packer: DIM must be a power of two >= 2 and ADDR_W left at its default");
  end

  state_e               state_q, state_d;
  logic                 wr_bank_q, rd_bank_q;
  logic [1:0]           bank_full_q, bank_full_d;
  logic [1:0]           tr_q;
  logic [CNT_W-1:0]     elem_cnt_q, elem_cnt_d;
  logic [SYM_IDX_W-1:0] sym_q, sym_d;

  logic                      wr_fire, commit_fire, frame_done, rd_en;
  logic [CNT_W-1:0]          rd_idx;
  logic [ELEM_W-1:0]         rd_data;
  logic [SPE-1:0][SYM_W-1:0] data_syms;
  logic [SYM_W-1:0]          sym_out;

  assign in_ready    = ~bank_full_q[wr_bank_q];
  assign wr_fire     = in_valid & in_ready;
  assign commit_fire = in_commit & in_ready;
  assign bank_full   = bank_full_q;
  assign data_syms   = rd_data;
  assign out_data    = sym_out;

  // Storage is always row-major; transposed readout swaps the counter halves.
  assign rd_idx = tr_q[rd_bank_q] ? {elem_cnt_d[ADDR_W-1:0], elem_cnt_d[CNT_W-1:ADDR_W]}
                                  : elem_cnt_d;

  matrix_packer_bank #(
    .AW (RAM_AW),
    .DW (ELEM_W)
  ) u_bank (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr ({wr_bank_q, in_row, in_col}),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr ({rd_bank_q, rd_idx}),
    .rd_data (rd_data)
  );

`ifdef MATRIX_PACKER_HEADER_EN
  localparam int HDR_DIM_W = ELEM_W - HDR_CTRL_W;
  localparam logic [HDR_DIM_W-1:0] HDR_DIM = HDR_DIM_W'(DIM - 1);
  logic [SPE-1:0][SYM_W-1:0] hdr_syms;
  assign hdr_syms = {tr_q[rd_bank_q], rd_bank_q, HDR_DIM};
`endif

  always_comb begin
    bank_full_d = bank_full_q;
    if (frame_done) begin
      bank_full_d[rd_bank_q] = 1'b0;
    end
    if (commit_fire) begin
      bank_full_d[wr_bank_q] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    sym_d      = sym_q;
    rd_en      = 1'b0;
    frame_done = 1'b0;
    out_valid  = 1'b0;
    out_first  = 1'b0;
    out_last   = 1'b0;
    sym_out    = '0;
    unique case (state_q)
      ST_IDLE: begin
        elem_cnt_d = '0;
        sym_d      = '0;
        if (bank_full_q[rd_bank_q]) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Element 0 is fetched ahead of any header so data follows it without a bubble.
        rd_en = 1'b1;
`ifdef MATRIX_PACKER_HEADER_EN
        state_d = ST_HEADER;
`else
        state_d = ST_STREAM;
`endif
      end
`ifdef MATRIX_PACKER_HEADER_EN
      ST_HEADER: begin
        out_valid = 1'b1;
        out_first = (sym_q == '0);
        sym_out   = hdr_syms[sym_q];
        if (out_ready) begin
          if (sym_q == SYM_LAST) begin
            sym_d   = '0;
            state_d = ST_STREAM;
          end else begin
            sym_d = sym_q + 1'b1;
          end
        end
      end
`endif
      ST_STREAM: begin
        out_valid = 1'b1;
        sym_out   = data_syms[sym_q];
        out_last  = (elem_cnt_q == ELEM_LAST) && (sym_q == SYM_LAST);
`ifndef MATRIX_PACKER_HEADER_EN
        out_first = (elem_cnt_q == '0) && (sym_q == '0);
`endif
        if (out_ready) begin
          if (sym_q != SYM_LAST) begin
            sym_d = sym_q + 1'b1;
          end else begin
            sym_d = '0;
            if (elem_cnt_q == ELEM_LAST) begin
              frame_done = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              elem_cnt_d = elem_cnt_q + 1'b1;
              rd_en      = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
      tr_q        <= 2'b00;
      elem_cnt_q  <= '0;
      sym_q       <= '0;
    end else begin
      state_q     <= state_d;
      bank_full_q <= bank_full_d;
      elem_cnt_q  <= elem_cnt_d;
      sym_q       <= sym_d;
      if (commit_fire) begin
        wr_bank_q       <= ~wr_bank_q;
        tr_q[wr_bank_q] <= transpose;
      end
      if (frame_done) begin
        rd_bank_q <= ~rd_bank_q;
      end
    end
  end

endmodule

// File: tb/tb_matrix_packer.sv
// Scoreboard bench for matrix_packer: directed matrices push expected symbols, a monitor pops and compares.
`timescale 1ns/1ps
module tb_matrix_packer;
  import matrix_packer_pkg::*;

  localparam int DIM    = 32;
  localparam int ELEM_W = 8;
  localparam int SYM_W  = 2;
  localparam int ADDR_W = 5;
  localparam int SPE    = SYMS_PER_ELEM;
`ifdef MATRIX_PACKER_HEADER_EN
  localparam int HS = SPE;
`else
  localparam int HS = 0;
`endif
  localparam int FRAME = DIM * DIM * SPE + HS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_row = '0;
  logic [ADDR_W-1:0] in_col = '0;
  logic [ELEM_W-1:0] in_data = '0;
  logic              in_commit = 1'b0;
  logic              transpose = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [SYM_W-1:0]  out_data;
  logic              out_first;
  logic              out_last;
  logic [1:0]        bank_full;

  matrix_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .in_col    (in_col),
    .in_data   (in_data),
    .in_commit (in_commit),
    .transpose (transpose),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last),
    .bank_full (bank_full)
  );

  typedef struct packed {
    logic [1:0] dat;
    logic       first;
    logic       last;
  } sym_t;

  sym_t       exp_q[$];
  sym_t       e;
  logic [7:0] mat [DIM][DIM];
  logic [1:0] cap [8192];
  int         fidx = 0;
  int         last_len = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         stall_checks = 0;
  bit         rnd_ready = 1'b0;
  bit         wbank = 1'b0;
  logic       stall_prev = 1'b0;
  logic       cont_prev = 1'b0;
  logic [3:0] prev_out = '0;

  int t1_exp [8]  = '{2, 2, 2, 2, 0, 0, 3, 3};
  int t2_exp [12] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0};
`ifdef MATRIX_PACKER_HEADER_EN
  int t5_exp [4]  = '{3, 3, 1, 2};
  localparam int T5_OFS = 0;
`else
  int t5_exp [4]  = '{0, 0, 1, 0};
  localparam int T5_OFS = 4;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
      cont_prev  = 1'b0;
    end else begin
      if (stall_prev) begin
        stall_checks++;
        chk("stall_hold", 32'({out_valid, out_data, out_first, out_last}), 32'({1'b1, prev_out}));
      end else if (cont_prev) begin
        chk("no_bubble", 32'(out_valid), 32'd1);
      end
      if (out_valid && out_ready) begin
        if (out_first) fidx = 0;
        if (fidx < 8192) cap[fidx] = out_data;
        if (exp_q.size() == 0) begin
          chk("unexpected_sym", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("sym%0d", fidx), 32'({out_data, out_first, out_last}), 32'(e));
        end
        if (out_last) last_len = fidx + 1;
        fidx++;
      end
      stall_prev = out_valid && !out_ready;
      cont_prev  = out_valid && out_ready && !out_last;
      prev_out   = {out_data, out_first, out_last};
    end
  end

  task automatic push_frame(input bit tr, input bit bank);
    logic [7:0] v;
    int r, c;
`ifdef MATRIX_PACKER_HEADER_EN
    logic [7:0] hdr;
    hdr = {tr, bank, 6'(DIM - 1)};
    for (int s = 0; s < SPE; s++) exp_q.push_back('{dat: hdr[2*s +: 2], first: (s == 0), last: 1'b0});
`else
    if (bank) r = 0;
`endif
    for (int k = 0; k < DIM * DIM; k++) begin
      r = tr ? (k % DIM) : (k / DIM);
      c = tr ? (k / DIM) : (k % DIM);
      v = mat[r][c];
      for (int s = 0; s < SPE; s++)
        exp_q.push_back('{dat: v[2*s +: 2], first: (HS == 0 && k == 0 && s == 0),
                          last: (k == DIM * DIM - 1 && s == SPE - 1)});
    end
  endtask

  task automatic load(input int kind, input bit commit_last, input bit tr);
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        logic [7:0] v;
        if (kind == 0) v = (i == j) ? 8'hAA : 8'hF0;
        else v = {4'(i), 4'(j)};
        mat[i][j] = v;
        in_valid  = 1'b1;
        in_row    = 5'(i);
        in_col    = 5'(j);
        in_data   = v;
        if (commit_last && i == DIM - 1 && j == DIM - 1) begin
          in_commit = 1'b1;
          transpose = tr;
          push_frame(tr, wbank);
          wbank = ~wbank;
        end
        @(posedge clk); #1;
      end
    end
    in_valid  = 1'b0;
    in_commit = 1'b0;
  endtask

  task automatic commit(input bit tr, output bit bank);
    in_commit = 1'b1;
    transpose = tr;
    bank = wbank;
    push_frame(tr, wbank);
    wbank = ~wbank;
    @(posedge clk); #1;
    in_commit = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bank_full != 2'b00) && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_bank_full_clear"}, 32'(bank_full), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    bit         b, ba, bb;
    logic [1:0] bf_exp;
    int         n;

    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_first", 32'(out_first), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_bank_full", 32'(bank_full), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // Test 1: diagonal pattern, row-major, commit latency
    load(0, 1'b0, 1'b0);
    chk("t1_idle_before_commit", 32'(out_valid), 32'd0);
    commit(1'b0, b);
    chk("t1_bank_full", 32'(bank_full), 32'd1);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    chk("t1_lat_n0", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_lat_n1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_lat_n2_valid", 32'(out_valid), 32'd1);
    chk("t1_lat_n2_first", 32'(out_first), 32'd1);
    drain("t1");
    chk("t1_frame_len", 32'(last_len), 32'(FRAME));
    for (int i = 0; i < 8; i++) chk($sformatf("t1_spot%0d", i), 32'(cap[HS + i]), 32'(t1_exp[i]));

    // Test 2: {i,j} pattern, transposed, last write in the commit cycle
    load(1, 1'b1, 1'b1);
    drain("t2");
    for (int i = 0; i < 12; i++) chk($sformatf("t2_spot%0d", i), 32'(cap[HS + i]), 32'(t2_exp[i]));

    // Test 3: test-1 matrix under random backpressure
    rnd_ready = 1'b1;
    load(0, 1'b0, 1'b0);
    commit(1'b0, b);
    drain("t3");
    rnd_ready = 1'b0;
    chk("t3_stalls_seen", 32'(stall_checks > 0), 32'd1);
    chk("t3_frame_len", 32'(last_len), 32'(FRAME));

    // Test 4: ping-pong, dropped write into the busy bank
    load(0, 1'b0, 1'b0);
    commit(1'b0, ba);
    bf_exp = 2'b00;
    bf_exp[ba] = 1'b1;
    chk("t4_a_full", 32'(bank_full), 32'(bf_exp));
    chk("t4_b_in_ready", 32'(in_ready), 32'd1);
    load(1, 1'b0, 1'b0);
    commit(1'b0, bb);
    chk("t4_both_full", 32'(bank_full), 32'd3);
    chk("t4_in_ready_low", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_row   = 5'd31;
    in_col   = 5'd5;
    in_data  = 8'h55;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (bank_full == 2'b11 && n < 10000) begin
      @(posedge clk); #1;
      n++;
    end
    bf_exp = 2'b11;
    bf_exp[ba] = 1'b0;
    chk("t4_a_done", 32'(bank_full), 32'(bf_exp));
    drain("t4");

    // Test 5: reset mid-stream, then a clean frame
    load(0, 1'b0, 1'b0);
    commit(1'b0, b);
    n = 0;
    while (exp_q.size() > FRAME - 1000 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_reached_1000", 32'(exp_q.size() <= FRAME - 1000), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_out_first", 32'(out_first), 32'd0);
    chk("t5_rst_out_last", 32'(out_last), 32'd0);
    chk("t5_rst_out_data", 32'(out_data), 32'd0);
    chk("t5_rst_bank_full", 32'(bank_full), 32'd0);
    chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    wbank = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    load(1, 1'b0, 1'b1);
    commit(1'b1, b);
    chk("t5_bank0", 32'(b), 32'd0);
    drain("t5");
    chk("t5_frame_len", 32'(last_len), 32'(FRAME));
    for (int i = 0; i < 4; i++) chk($sformatf("t5_spot%0d", i), 32'(cap[T5_OFS + i]), 32'(t5_exp[i]));

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
